// File: rtl/systolic_ser_pkg.sv
// Shared types and default sizing for the systolic result serializer.
package systolic_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam int SER_WORD_W  = 64;
  localparam int SER_N_WORDS = 8;

endpackage

// File: rtl/systolic_pingpong_buf.sv
// Two-slot ping-pong store for wide result vectors; slots are filled and drained in order.
// With SER_PARITY_EN defined the non-read slot's data is also exposed for look-ahead.
module systolic_pingpong_buf
  import systolic_ser_pkg::*;
#(
  parameter int WORD_W  = SER_WORD_W,
  parameter int N_WORDS = SER_N_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WORD_W*N_WORDS-1:0] wr_data,
  input  logic                      load,
  input  logic                      rd_done,
  output logic                      load_ready,
  output logic [WORD_W*N_WORDS-1:0] rd_data,
  output logic                      rd_full,
  output logic                      other_full
`ifdef SER_PARITY_EN
  ,
  output logic [WORD_W*N_WORDS-1:0] other_data
`endif
);

  localparam int DATA_W = WORD_W * N_WORDS;

  slot_state_t       slot_st   [2];
  logic [DATA_W-1:0] slot_data [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              capture;

  assign capture = load && load_ready;

  always_ff @(posedge clk) begin
    if (capture) begin
      slot_data[wr_ptr] <= wr_data;
    end
  end

  // In-order use guarantees capture and release never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_st[0] <= EMPTY;
      slot_st[1] <= EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr <= ~wr_ptr;
      end
      if (rd_done) begin
        rd_ptr <= ~rd_ptr;
      end
      for (int i = 0; i < 2; i++) begin
        if (capture && (wr_ptr == 1'(i))) begin
          slot_st[i] <= FULL;
        end else if (rd_done && (rd_ptr == 1'(i))) begin
          slot_st[i] <= EMPTY;
        end
      end
    end
  end

  assign load_ready = (slot_st[0] == EMPTY) || (slot_st[1] == EMPTY);
  assign rd_full    = (slot_st[rd_ptr] == FULL);
  assign other_full = (slot_st[~rd_ptr] == FULL);
  assign rd_data    = slot_data[rd_ptr];

`ifdef SER_PARITY_EN
  assign other_data = slot_data[~rd_ptr];
`endif

endmodule

// File: rtl/systolic_result_serializer.sv
// Streams buffered systolic result vectors out as WORD_W-bit valid/ready beats.
// Optional SER_PARITY_EN adds a registered even-parity output dest_parity.
module systolic_result_serializer
  import systolic_ser_pkg::*;
#(
  parameter int WORD_W    = SER_WORD_W,
  parameter int N_WORDS   = SER_N_WORDS,
  parameter int MSW_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WORD_W*N_WORDS-1:0]  systolic_output,
  input  logic                       load,
  output logic                       load_ready,
  output logic                       dest_valid,
  output logic [WORD_W-1:0]          dest_data,
  output logic                       dest_last,
  output logic [$clog2(N_WORDS)-1:0] beat_idx,
  input  logic                       src_ready,
  output logic                       tx_done
`ifdef SER_PARITY_EN
  ,
  output logic                       dest_parity
`endif
);

  localparam int DATA_W = WORD_W * N_WORDS;
  localparam int IDX_W  = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  ser_state_t        state;
  ser_state_t        state_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              handshake;
  logic              last_hs;
  logic              rd_done;
  logic              rd_full;
  logic              other_full;
  logic [DATA_W-1:0] rd_data;
`ifdef SER_PARITY_EN
  logic [DATA_W-1:0] other_data;
  logic [DATA_W-1:0] nxt_vec;
`endif

  // Word order within a vector is fixed by MSW_FIRST; stored slots are never shifted.
  function automatic logic [WORD_W-1:0] select_beat(input logic [DATA_W-1:0] vec,
                                                    input logic [IDX_W-1:0]  b);
    int w;
    if (MSW_FIRST != 0) begin
      w = N_WORDS - 1 - int'(b);
    end else begin
      w = int'(b);
    end
    return vec[w*WORD_W +: WORD_W];
  endfunction

  systolic_pingpong_buf #(
    .WORD_W (WORD_W),
    .N_WORDS(N_WORDS)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (systolic_output),
    .load      (load),
    .rd_done   (rd_done),
    .load_ready(load_ready),
    .rd_data   (rd_data),
    .rd_full   (rd_full),
    .other_full(other_full)
`ifdef SER_PARITY_EN
    ,
    .other_data(other_data)
`endif
  );

  assign dest_valid = (state == SEND);
  assign handshake  = dest_valid && src_ready;
  assign last_hs    = handshake && (beat_idx == LAST_IDX);
  assign dest_last  = dest_valid && (beat_idx == LAST_IDX);
  assign dest_data  = dest_valid ? select_beat(rd_data, beat_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_idx <= '0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_idx <= idx_nxt;
      tx_done  <= last_hs;
    end
  end

  // Finishing a vector with the other slot already full hands over with no idle cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = beat_idx;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_full) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (handshake) begin
          if (beat_idx == LAST_IDX) begin
            rd_done   = 1'b1;
            idx_nxt   = '0;
            state_nxt = other_full ? SEND : IDLE;
          end else begin
            idx_nxt = beat_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef SER_PARITY_EN
  // Parity is computed for the beat that will be presented after this edge.
  assign nxt_vec = (last_hs && other_full) ? other_data : rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      dest_parity <= 1'b0;
    end else begin
      dest_parity <= (state_nxt == SEND) ? ^select_beat(nxt_vec, idx_nxt) : 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_result_serializer.sv
// Directed self-checking bench for systolic_result_serializer (64x8 MSW-first and 32x4 LSW-first).
// Parity checks are compiled in when SER_PARITY_EN is defined.
module tb_systolic_result_serializer;

  localparam int W  = 64;
  localparam int N  = 8;
  localparam int DW = W * N;

  localparam logic [DW-1:0] VEC_A = {
    64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'h1111111111111111, 64'h2222222222222222,
    64'h3333333333333333, 64'h4444444444444444, 64'h5555555555555555, 64'hF0F1F2F3F4F5F6F7};
  localparam logic [DW-1:0] VEC_B = {
    64'hB0B0000000000000, 64'hB0B0000000000001, 64'hB0B0000000000002, 64'hB0B0000000000003,
    64'hB0B0000000000004, 64'hB0B0000000000005, 64'hB0B0000000000006, 64'hB0B0000000000007};
  localparam logic [DW-1:0] VEC_C = {8{64'hCCCCCCCCCCCCCCCC}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW-1:0] sysOut;
  logic          load;
  logic          srcReady;
  logic          loadReady;
  logic          destValid;
  logic [W-1:0]  destData;
  logic          destLast;
  logic [2:0]    beatIdx;
  logic          txDone;

  logic [127:0]  sysOut4;
  logic          load4;
  logic          srcReady4;
  logic          loadReady4;
  logic          destValid4;
  logic [31:0]   destData4;
  logic          destLast4;
  logic [1:0]    beatIdx4;
  logic          txDone4;

`ifdef SER_PARITY_EN
  logic          destParity;
  logic          destParity4;
`endif

  systolic_result_serializer #(
    .WORD_W(64), .N_WORDS(8), .MSW_FIRST(1)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .systolic_output(sysOut),
    .load           (load),
    .load_ready     (loadReady),
    .dest_valid     (destValid),
    .dest_data      (destData),
    .dest_last      (destLast),
    .beat_idx       (beatIdx),
    .src_ready      (srcReady),
    .tx_done        (txDone)
`ifdef SER_PARITY_EN
    ,
    .dest_parity    (destParity)
`endif
  );

  systolic_result_serializer #(
    .WORD_W(32), .N_WORDS(4), .MSW_FIRST(0)
  ) u_dut4 (
    .clk            (clk),
    .reset          (reset),
    .systolic_output(sysOut4),
    .load           (load4),
    .load_ready     (loadReady4),
    .dest_valid     (destValid4),
    .dest_data      (destData4),
    .dest_last      (destLast4),
    .beat_idx       (beatIdx4),
    .src_ready      (srcReady4),
    .tx_done        (txDone4)
`ifdef SER_PARITY_EN
    ,
    .dest_parity    (destParity4)
`endif
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] expWords [$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it; outputs are sampled here, inputs changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for a single capture edge.
  task automatic applyStimulus(input logic [DW-1:0] vec);
    load   = 1'b1;
    sysOut = vec;
    tick();
    load   = 1'b0;
  endtask

  // Check n consecutive beats against expWords with src_ready held high, then the tx_done pulse.
  task automatic expectStream(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      checkOutput($sformatf("%s b%0d valid", tag, c), destValid, 1'b1);
      checkOutput($sformatf("%s b%0d data", tag, c), destData, expWords[c]);
      checkOutput($sformatf("%s b%0d idx", tag, c), beatIdx, 64'(c % 8));
      checkOutput($sformatf("%s b%0d last", tag, c), destLast, (c % 8) == 7);
      checkOutput($sformatf("%s b%0d tx", tag, c), txDone, (c > 0) && ((c % 8) == 0));
      tick();
    end
    checkOutput({tag, " tx_done"}, txDone, 1'b1);
    checkOutput({tag, " drained"}, destValid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs;
    int txCount;
    bit started;

    reset     = 1'b1;
    load      = 1'b0;
    srcReady  = 1'b0;
    sysOut    = '0;
    load4     = 1'b0;
    srcReady4 = 1'b0;
    sysOut4   = '0;
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst load_ready", loadReady, 1'b1);
    checkOutput("rst dest_valid", destValid, 1'b0);
    checkOutput("rst dest_data", destData, 64'h0);
    checkOutput("rst dest_last", destLast, 1'b0);
    checkOutput("rst beat_idx", beatIdx, 64'h0);
    checkOutput("rst tx_done", txDone, 1'b0);
    checkOutput("rst4 load_ready", loadReady4, 1'b1);
    checkOutput("rst4 dest_valid", destValid4, 1'b0);
`ifdef SER_PARITY_EN
    checkOutput("rst dest_parity", destParity, 1'b0);
`endif
    reset = 1'b0;
    tick();

    $display("[TB] single vector, continuous ready");
    expWords = '{64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'h1111111111111111,
                 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444,
                 64'h5555555555555555, 64'hF0F1F2F3F4F5F6F7};
    srcReady = 1'b1;
    applyStimulus(VEC_A);
    checkOutput("t1 capture cycle valid", destValid, 1'b0);
    checkOutput("t1 capture cycle load_ready", loadReady, 1'b1);
    tick();
    expectStream("t1", 8);
    tick();
    checkOutput("t1 tx_done single", txDone, 1'b0);

    $display("[TB] single vector, stalling ready");
    applyStimulus(VEC_A);
    hs      = 0;
    txCount = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 64 && hs < 8; cyc++) begin
      srcReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (txDone) txCount++;
      if (started) checkOutput($sformatf("t2 c%0d valid held", cyc), destValid, 1'b1);
      if (destValid) begin
        started = 1'b1;
        checkOutput($sformatf("t2 c%0d data", cyc), destData, expWords[hs]);
        checkOutput($sformatf("t2 c%0d idx", cyc), beatIdx, 64'(hs));
        if (srcReady) hs++;
      end
      tick();
    end
    checkOutput("t2 handshakes", hs, 64'd8);
    checkOutput("t2 early tx_done", txCount, 64'd0);
    checkOutput("t2 tx_done", txDone, 1'b1);
    srcReady = 1'b1;
    tick();
    checkOutput("t2 tx_done single", txDone, 1'b0);

    $display("[TB] back-to-back vectors with both slots full");
    for (int b = 0; b < 8; b++) expWords.push_back(64'hB0B0000000000000 | 64'(b));
    applyStimulus(VEC_A);
    checkOutput("t3 one slot free", loadReady, 1'b1);
    tick();
    for (int c = 0; c < 16; c++) begin
      checkOutput($sformatf("t3 b%0d valid", c), destValid, 1'b1);
      checkOutput($sformatf("t3 b%0d data", c), destData, expWords[c]);
      checkOutput($sformatf("t3 b%0d idx", c), beatIdx, 64'(c % 8));
      checkOutput($sformatf("t3 b%0d last", c), destLast, (c % 8) == 7);
      checkOutput($sformatf("t3 b%0d tx", c), txDone, c == 8);
      if (c == 0) begin
        load   = 1'b1;
        sysOut = VEC_B;
      end else if (c == 1) begin
        checkOutput("t3 both full load_ready", loadReady, 1'b0);
        load   = 1'b1;
        sysOut = VEC_C;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    checkOutput("t3 second tx_done", txDone, 1'b1);
    checkOutput("t3 drained", destValid, 1'b0);
    tick();
    checkOutput("t3 third load ignored", destValid, 1'b0);
    checkOutput("t3 tx_done single", txDone, 1'b0);
    checkOutput("t3 load_ready", loadReady, 1'b1);

    $display("[TB] reset mid-transfer");
    applyStimulus(VEC_A);
    tick();
    load   = 1'b1;
    sysOut = VEC_B;
    tick();
    load = 1'b0;
    tick();
    tick();
    checkOutput("t4 beat3 idx", beatIdx, 64'd3);
    checkOutput("t4 beat3 data", destData, 64'h2222222222222222);
    reset = 1'b1;
    tick();
    checkOutput("t4 abort valid", destValid, 1'b0);
    checkOutput("t4 abort load_ready", loadReady, 1'b1);
    checkOutput("t4 abort beat_idx", beatIdx, 64'h0);
    checkOutput("t4 abort tx_done", txDone, 1'b0);
    checkOutput("t4 abort data", destData, 64'h0);
    reset = 1'b0;
    tick();
    checkOutput("t4 post valid", destValid, 1'b0);
    checkOutput("t4 post tx_done", txDone, 1'b0);
    tick();
    checkOutput("t4 buffered discarded", destValid, 1'b0);
    expWords = '{};
    for (int b = 0; b < 8; b++) expWords.push_back(64'hB0B0000000000000 | 64'(b));
    applyStimulus(VEC_B);
    tick();
    expectStream("t4 fresh", 8);
    tick();

    $display("[TB] 32x4 LSW-first");
    srcReady4 = 1'b1;
    load4     = 1'b1;
    sysOut4   = 128'h00000003_00000002_00000001_00000000;
    tick();
    load4 = 1'b0;
    checkOutput("t5 capture cycle valid", destValid4, 1'b0);
    tick();
    for (int b = 0; b < 4; b++) begin
      checkOutput($sformatf("t5 b%0d valid", b), destValid4, 1'b1);
      checkOutput($sformatf("t5 b%0d data", b), destData4, 64'(b));
      checkOutput($sformatf("t5 b%0d idx", b), beatIdx4, 64'(b));
      checkOutput($sformatf("t5 b%0d last", b), destLast4, b == 3);
`ifdef SER_PARITY_EN
      checkOutput($sformatf("t5 b%0d parity", b), destParity4, (b == 1) || (b == 2));
`endif
      tick();
    end
    checkOutput("t5 tx_done", txDone4, 1'b1);
    checkOutput("t5 drained", destValid4, 1'b0);
    tick();
    checkOutput("t5 tx_done single", txDone4, 1'b0);

`ifdef SER_PARITY_EN
    $display("[TB] parity");
    begin
      logic expPar [8];
      expPar   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      expWords = '{64'h1, 64'h3, 64'h7, 64'h0, 64'h8000000000000000,
                   64'hFFFFFFFFFFFFFFFF, 64'h0101010101010101, 64'h10};
      applyStimulus({64'h1, 64'h3, 64'h7, 64'h0, 64'h8000000000000000,
                     64'hFFFFFFFFFFFFFFFF, 64'h0101010101010101, 64'h10});
      tick();
      for (int b = 0; b < 8; b++) begin
        checkOutput($sformatf("t6 b%0d data", b), destData, expWords[b]);
        checkOutput($sformatf("t6 b%0d parity", b), destParity, expPar[b]);
        tick();
      end
      checkOutput("t6 idle parity", destParity, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_result_serializer.md
Name: systolic_result_serializer

Overview:
Captures wide systolic-array result vectors (N_WORDS x WORD_W bits) into a two-slot ping-pong buffer and streams them out as WORD_W-bit beats over a valid/ready interface.
- Sits between the systolic array output and the ready/valid transmit path.
- Generalises the single 512-bit buffer/feeder into a parametrised block.
- Accepts the next matrix result while the previous one is still draining, and flags the last beat.

Parameters:
- WORD_W, 64, beat width in bits.
- N_WORDS, 8, beats per result vector; must be >= 2. Derived localparams: DATA_W = WORD_W*N_WORDS; IDX_W = $clog2(N_WORDS).
- MSW_FIRST, 1, 1 = beat 0 is bits [DATA_W-1 -: WORD_W]; 0 = beat 0 is bits [WORD_W-1:0].

Ports:
- clk  input  1  system clock; single clock domain, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- systolic_output  input  DATA_W  result vector to capture.
- load  input  1  capture request; takes effect only when load_ready=1.
- load_ready  output  1  at least one buffer slot is empty.
- dest_valid  output  1  dest_data holds a valid beat.
- dest_data  output  WORD_W  current beat.
- dest_last  output  1  current beat is beat N_WORDS-1 of its vector.
- beat_idx  output  IDX_W  index of the current beat within its vector.
- src_ready  input  1  downstream accepts a beat; a transfer occurs when dest_valid && src_ready.
- tx_done  output  1  one-cycle pulse after the last beat of a vector is accepted.

Behaviour:
- Reset (sync, active-high) values:
  - Outputs: load_ready=1, dest_valid=0, dest_data=0, dest_last=0, beat_idx=0, tx_done=0.
  - State: both slots EMPTY, write pointer=0, read pointer=0, FSM=IDLE.
- Reset asserted mid-transfer aborts everything. Both buffered vectors are discarded, and no tx_done is emitted for the aborted vector.
- load_ready is a function of registered state only (1 when any slot is EMPTY), never of src_ready.
  - With both slots FULL it is 0, even during a last-beat handshake in the same cycle.
  - load while load_ready=0 is ignored; no data is overwritten.
- Capture on load && load_ready:
  - systolic_output is written into the slot at the write pointer, which is marked FULL.
  - The write pointer toggles.
- FSM states and transitions:
  - IDLE -> SEND when the read-pointer slot is FULL.
  - SEND -> SEND on a non-last handshake: beat_idx increments.
  - SEND -> SEND on a last handshake when the other slot is FULL: the finished slot is marked EMPTY, the read pointer toggles, beat_idx returns to 0, and dest_valid stays 1. There is no bubble between vectors.
  - SEND -> IDLE on a last handshake when the other slot is EMPTY.
- Latency: a load accepted at edge k with the FSM in IDLE gives dest_valid=1 with beat 0 from cycle k+1.
- Hold rule: while dest_valid && !src_ready, dest_data, dest_last and beat_idx hold stable. dest_valid never deasserts without a handshake, except on reset.
- Beat selection: beat b = word (N_WORDS-1-b) when MSW_FIRST=1, otherwise word b. dest_data is a mux of the read slot indexed by beat_idx. No shifting of stored data; the slot is immutable while FULL.
- dest_last = dest_valid && (beat_idx == N_WORDS-1).
- tx_done is registered and asserted in the cycle following the last-beat handshake, for exactly 1 cycle.
- Simultaneous load and last-beat handshake in the same cycle with one slot EMPTY: both occur. The freed slot becomes EMPTY at the same edge the new vector fills the other slot.

Optional Feature:
- Macro SER_PARITY_EN.
- When defined: an extra output port dest_parity (1 bit) equal to the even parity (XOR reduction) of dest_data, registered alongside the beat. It follows the same hold rule and resets to 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package systolic_ser_pkg holds:
  - the FSM state enum (IDLE, SEND);
  - the slot-status enum (EMPTY, FULL);
  - default constants SER_WORD_W=64 and SER_N_WORDS=8.
- One sub-module, systolic_pingpong_buf: two DATA_W slots with FULL flags, write/read pointers and load_ready generation.
  - Exposes the read-slot data and its FULL flag, plus the other slot's FULL flag.
  - The serializer FSM, beat counter and output mux stay in the top.

Test Plan:
1. Load 512'hFEDCBA9876543210_..._F0F1F2F3F4F5F6F7 with src_ready=1 continuously (MSW_FIRST=1) -> 8 consecutive beats from cycle k+1: beat0=64'hFEDCBA9876543210, beat7=64'hF0F1F2F3F4F5F6F7 with dest_last=1; tx_done pulses once, the cycle after beat7.
2. Same load, src_ready toggling 1,0,0,1,... -> no beat lost or duplicated; dest_data and beat_idx stable during every stall; 8 handshakes total.
3. Load vector A, then vector B two cycles later, then a third load while both are FULL -> load_ready=0 and the third load is ignored; B's beat0 follows A's beat7 with dest_valid held high (zero-gap); two tx_done pulses.
4. Assert reset during beat 3 of vector A with B buffered -> the next cycle shows dest_valid=0, load_ready=1, beat_idx=0 and no tx_done; a fresh load afterwards streams from beat0.
5. MSW_FIRST=0, WORD_W=32, N_WORDS=4, load 128'h00000003_00000002_00000001_00000000 -> beats 0,1,2,3 in order; dest_last only on 32'h00000003.
6. With SER_PARITY_EN defined, beat 64'h0000000000000001 -> dest_parity=1; beat 64'h0000000000000003 -> dest_parity=0.
